muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Handshake and result bus for the iterative RV32M multiply/divide unit.
// The core drives the slave side; an issuing pipeline or bench drives the master side.
interface muldiv_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        reg_write;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_in,
        input  busy, done, result, rd_out, reg_write
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_in,
        output busy, done, result, rd_out, reg_write
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply and restoring divide,
// with single-cycle bypass for divide-by-zero and signed overflow.
module muldiv_unit (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] acc_q, acc_d;       // multiply: product; divide: {remainder, dividend/quotient}
    logic [63:0] mcand_q, mcand_d;   // multiply: shifted multiplicand; divide: divisor in [31:0]
    logic [31:0] mplier_q, mplier_d;
    logic        msign_q, msign_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_q, rd_d;

    // Operand decode at the accepting edge
    logic        div_op, div_signed, a_sx, b_sx, div_zero, div_ovf;
    logic [31:0] a_mag, b_mag;

    assign div_op     = bus.funct3[2];
    assign div_signed = bus.funct3[2] & ~bus.funct3[0];
    assign a_sx       = (bus.funct3 == 3'b001 || bus.funct3 == 3'b010) & bus.rs1_data[31];
    assign b_sx       = (bus.funct3 == 3'b001) & bus.rs2_data[31];
    assign div_zero   = (bus.rs2_data == 32'd0);
    assign div_ovf    = div_signed && bus.rs1_data == 32'h8000_0000 && bus.rs2_data == 32'hFFFF_FFFF;
    assign a_mag      = (div_signed && bus.rs1_data[31]) ? -bus.rs1_data : bus.rs1_data;
    assign b_mag      = (div_signed && bus.rs2_data[31]) ? -bus.rs2_data : bus.rs2_data;

    // One iteration of each algorithm; the last multiply step subtracts for a negative multiplier
    logic [63:0] mul_step, div_step, step_acc;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] quo, rem;

    assign mul_step = acc_q + (mplier_q[0] ? mcand_q : 64'd0)
                    - ((cnt_q == 6'd31 && msign_q) ? {mcand_q[62:0], 1'b0} : 64'd0);
    assign shifted  = {acc_q[63:32], acc_q[31]};
    assign fits     = shifted >= {1'b0, mcand_q[31:0]};
    assign div_step = {fits ? shifted[31:0] - mcand_q[31:0] : shifted[31:0], acc_q[30:0], fits};
    assign step_acc = op_q[2] ? div_step : mul_step;
    assign quo      = negq_q ? -step_acc[31:0] : step_acc[31:0];
    assign rem      = negr_q ? -step_acc[63:32] : step_acc[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            msign_q  <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            msign_q  <= msign_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal holds by default so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        msign_d  = msign_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        rd_d     = rd_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d  = bus.funct3;
                    rd_d  = bus.rd_in;
                    cnt_d = '0;
                    if (div_op && div_zero) begin
                        state_d  = DONE;
                        result_d = bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF;
                    end else if (div_ovf) begin
                        state_d  = DONE;
                        result_d = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state_d = CALC;
                        negq_d  = div_signed && (bus.rs1_data[31] ^ bus.rs2_data[31]);
                        negr_d  = div_signed && bus.rs1_data[31];
                        if (div_op) begin
                            acc_d   = {32'd0, a_mag};
                            mcand_d = {32'd0, b_mag};
                        end else begin
                            acc_d    = '0;
                            mcand_d  = {{32{a_sx}}, bus.rs1_data};
                            mplier_d = bus.rs2_data;
                            msign_d  = b_sx;
                        end
                    end
                end
            end
            CALC: begin
                acc_d    = step_acc;
                mcand_d  = op_q[2] ? mcand_q : {mcand_q[62:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                    case (op_q)
                        3'b000:                 result_d = step_acc[31:0];
                        3'b001, 3'b010, 3'b011: result_d = step_acc[63:32];
                        3'b100, 3'b101:         result_d = quo;
                        default:                result_d = rem;
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_q;
    assign bus.reg_write = (state_q == DONE) && (rd_q != 5'd0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: every RV32M op, bypass cases,
// ignored start while busy, mid-operation reset and back-to-back issue.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    muldiv_if bus ();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request so that the next rising edge is E0, then scramble operands just after it
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.funct3   = op;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_in    = rd;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.rs1_data = ~a;
        bus.rs2_data = b ^ 32'h5A5A_A5A5;
        bus.rd_in    = ~rd;
        bus.funct3   = ~op;
    endtask

    // Issue, wait for done (bounded), check latency/result/controls, then check the hold cycle
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int   n;
        logic seen;
        issue(op, a, b, rd);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) check({tag, "_busy_e0"}, bus.busy, 32'd1);
            if (bus.done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 32'd1);
        check({tag, "_latency"}, n - 1, exp_lat);
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_rd_out"}, bus.rd_out, rd);
        check({tag, "_reg_write"}, bus.reg_write, (rd != 5'd0));
        check({tag, "_busy_done"}, bus.busy, 32'd1);
        @(negedge clk);
        check({tag, "_busy_after"}, bus.busy, 32'd0);
        check({tag, "_done_after"}, bus.done, 32'd0);
        check({tag, "_result_hold"}, bus.result, exp_res);
        check({tag, "_rd_hold"}, bus.rd_out, rd);
    endtask

    initial begin
        int       ndone;
        logic [31:0] res_at_done;
        bus.start    = 1'b0;
        bus.funct3   = 3'b000;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.rd_in    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 32'd0);
        check("rst_done", bus.done, 32'd0);
        check("rst_reg_write", bus.reg_write, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_rd_out", bus.rd_out, 32'd0);
        rst = 1'b0;

        run_op("mul_7x5",     3'b000, 32'd7,          32'd5,          5'd3,  32'd35,         32);
        run_op("mul_big",     3'b000, 32'h1234_5678,  32'h10,         5'd9,  32'h2345_6780,  32);
        run_op("mulh_m1m1",   3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'h0000_0000,  32);
        run_op("mulhu_m1m1",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  32'hFFFF_FFFE,  32);
        run_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF,  32'd2,          5'd6,  32'hFFFF_FFFF,  32);
        run_op("mulhu_hi",    3'b011, 32'h8000_0000,  32'd4,          5'd7,  32'd2,          32);
        run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFD,  32);
        run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9,  32'd2,          5'd10, 32'hFFFF_FFFF,  32);
        run_op("divu_7_2",    3'b101, 32'd7,          32'd2,          5'd11, 32'd3,          32);
        run_op("remu_7_2",    3'b111, 32'd7,          32'd2,          5'd12, 32'd1,          32);
        run_op("div_m100_m7", 3'b100, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd13, 32'd14,         32);
        run_op("rem_m100_m7", 3'b110, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd14, 32'hFFFF_FFFE,  32);
        run_op("divu_by0",    3'b101, 32'd9,          32'd0,          5'd15, 32'hFFFF_FFFF,  0);
        run_op("rem_by0",     3'b110, 32'd9,          32'd0,          5'd16, 32'd9,          0);
        run_op("div_ovf",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'h8000_0000,  0);
        run_op("rem_ovf",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd18, 32'd0,          0);
        run_op("mul_rd0",     3'b000, 32'd123,        32'd1000,       5'd0,  32'd123000,     32);

        // A start pulse at E0+10 must be ignored; exactly one done follows
        issue(3'b000, 32'd6, 32'd7, 5'd5);
        repeat (9) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.funct3   = 3'b101;
        bus.rs1_data = 32'd100;
        bus.rs2_data = 32'd3;
        bus.rd_in    = 5'd21;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone       = 0;
        res_at_done = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                res_at_done = bus.result;
            end
        end
        check("ign_done_count", ndone, 32'd1);
        check("ign_result", res_at_done, 32'd42);
        check("ign_rd_out", bus.rd_out, 32'd5);
        check("ign_busy_end", bus.busy, 32'd0);

        // Reset at E0+15 abandons the operation with no done through E0+40
        issue(3'b000, 32'd11, 32'd13, 5'd22);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", bus.busy, 32'd0);
        check("midrst_done", bus.done, 32'd0);
        check("midrst_result", bus.result, 32'd0);
        check("midrst_rd_out", bus.rd_out, 32'd0);
        rst   = 1'b0;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("midrst_no_done", ndone, 32'd0);
        run_op("mul_3x4_after_rst", 3'b000, 32'd3, 32'd4, 5'd1, 32'd12, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
